// File: rtl/add_seq_ctrl_if.sv
// Start/result bundle between a control front end and the byte-serial add/sub sequencer.
// The master drives the request and operands; the slave (sequencer) returns status and result.
interface add_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, op_a, op_b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_a, op_b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// Byte-serial wide adder/subtractor: latches operands on start and pushes one byte per
// cycle, LSB first, through a single shared 8-bit add slice, chaining C8 into the next C0.

module add (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       C0,
    input  logic       E,
    output logic [7:0] S,
    output logic       C8
);
    logic [8:0] c;

    // Ripple-carry slice; outputs are forced to zero while the slice is disabled.
    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = C0;
        for (int i = 0; i < 8; i++) begin
            S[i]     = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        if (!E) begin
            S = '0;
        end
        C8 = E & c[8];
    end
endmodule

module add_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst,
    add_seq_ctrl_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          cout_reg;
    logic          ovf_reg;

    logic [IW+2:0] byte_lsb;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic          add_en;
    logic [7:0]    add_s;
    logic          add_c8;
    logic          last;

    assign byte_lsb = {idx, 3'b000};
    assign a_byte   = a_reg[byte_lsb +: 8];
    assign b_byte   = b_reg[byte_lsb +: 8];
    assign add_en   = (state == RUN);
    assign last     = (idx == IW'(NBYTES - 1));

    add u_add (
        .A  (a_byte),
        .B  (b_byte),
        .C0 (carry),
        .E  (add_en),
        .S  (add_s),
        .C8 (add_c8)
    );

    // B is stored pre-inverted for subtraction so RUN never needs to know the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg    <= bus.op_a;
                        b_reg    <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry    <= bus.sub | bus.cin;
                        idx      <= '0;
                        sum_reg  <= '0;
                        cout_reg <= 1'b0;
                        ovf_reg  <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[byte_lsb +: 8] <= add_s;
                    carry                  <= add_c8;
                    if (last) begin
                        cout_reg <= add_c8;
                        ovf_reg  <= (a_byte[7] == b_byte[7]) && (add_s[7] != a_byte[7]);
                        idx      <= '0;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl with NBYTES=4: arithmetic vectors, held-start handshake
// and mid-operation reset, sampled on the falling edge.
module tb_add_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    add_seq_ctrl_if #(.NBYTES(4)) bus ();

    add_seq_ctrl #(.NBYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; operands are scrambled right after acceptance.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input logic [31:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        bus.sub   = s;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.op_a  = 32'hDEADBEEF;
            bus.op_b  = 32'hCAFEF00D;
            bus.sub   = ~s;
            check($sformatf("%s busy%0d", tag, i), {31'd0, bus.busy}, 32'd1);
            check($sformatf("%s nodone%0d", tag, i), {31'd0, bus.done}, 32'd0);
        end
        @(negedge clk);
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " busy_low"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " sum"}, bus.sum, exp_sum);
        check({tag, " cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
        check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
        @(negedge clk);
        check({tag, " done_fall"}, {31'd0, bus.done}, 32'd0);
        check({tag, " sum_hold"}, bus.sum, exp_sum);
    endtask

    initial begin
        int p;
        int done_seen;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst sum", bus.sum, 32'd0);
        check("rst cout", {31'd0, bus.cout}, 32'd0);
        check("rst ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst E", {31'd0, dut.add_en}, 32'd0);
        rst = 1'b0;

        run_op("add_basic", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
        run_op("add_chain", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op("add_cin",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("sub_neg",   32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub_pos",   32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
        run_op("ovf_add",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("ovf_sub",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // Held start: accepts at edges 0, 6, 12 with op_a = 0x100 + edge number.
        done_seen = 0;
        bus.op_b  = 32'h10;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        for (int t = 0; t < 18; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                p = (t - 1) % 6;
                check($sformatf("hs busy t%0d", t), {31'd0, bus.busy}, (p <= 3) ? 32'd1 : 32'd0);
                check($sformatf("hs done t%0d", t), {31'd0, bus.done}, (p == 4) ? 32'd1 : 32'd0);
                check($sformatf("hs E t%0d", t), {31'd0, dut.add_en}, (p <= 3) ? 32'd1 : 32'd0);
                if (bus.done) done_seen++;
                if (p == 4) begin
                    check($sformatf("hs sum t%0d", t), bus.sum, 32'h110 + 32'(t - 5));
                end
            end
            bus.start = 1'b1;
            bus.op_a  = 32'h100 + 32'(t);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("hs done_count", 32'(done_seen), 32'd3);
        repeat (6) @(negedge clk);

        // Reset pulse on the second RUN edge aborts the operation.
        bus.start = 1'b1;
        bus.op_a  = 32'h11111111;
        bus.op_b  = 32'h22222222;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("abort partial", bus.sum, 32'h00000033);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort sum", bus.sum, 32'd0);
        check("abort cout", {31'd0, bus.cout}, 32'd0);
        check("abort ovf", {31'd0, bus.ovf}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort quiet", 32'(done_seen), 32'd0);

        run_op("after_rst", 32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
